// File: rtl/spi_pkg.sv
// Shared FSM encoding and default sizing for the SPI master.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        XFER  = 2'd2,
        HOLD  = 2'd3
    } spi_state_e;

    localparam int unsigned DEFAULT_DATA_WIDTH = 8;
    localparam int unsigned DEFAULT_CLK_DIV    = 4;

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period tick generator and spi_clk level register.
// spi_clk only toggles on a tick while tgl_i is high.
module spi_clk_gen
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic clr_i,
    input  logic tgl_i,
    output logic tick_o,
    output logic spi_clk_o
);

    localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

    logic [7:0] cnt_q, cnt_d;
    logic       spi_clk_q, spi_clk_d;

    assign tick_o    = en_i && (cnt_q == LAST);
    assign spi_clk_o = spi_clk_q;

    always_comb begin
        cnt_d     = cnt_q;
        spi_clk_d = spi_clk_q;
        if (clr_i) begin
            cnt_d     = '0;
            spi_clk_d = 1'b0;
        end else if (en_i) begin
            if (tick_o) begin
                cnt_d = '0;
                if (tgl_i) begin
                    spi_clk_d = ~spi_clk_q;
                end
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q     <= '0;
            spi_clk_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            spi_clk_q <= spi_clk_d;
        end
    end

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master: LSB-first transmit, MSB-first receive.
// Define SPI_MASTER_LOOPBACK_EN to feed internal mosi back into the receiver.
module spi_master
    import spi_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned CLK_DIV    = DEFAULT_CLK_DIV
) (
    input  logic                  sclk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  spi_clk,
    output logic                  cs_n,
    output logic                  mosi,
    input  logic                  miso
);

    localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);

    spi_state_e            state_q, state_d;
    logic                  cs_n_q, cs_n_d;
    logic                  done_q, done_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic [DATA_WIDTH-1:0] tx_q, tx_d;
    logic [DATA_WIDTH-1:0] rx_q, rx_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic                  tick, gen_clr, gen_tgl, rx_bit;

    assign gen_clr  = (state_q == IDLE);
    assign gen_tgl  = (state_q == XFER);
    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign data_out = data_out_q;
    assign cs_n     = cs_n_q;
    assign mosi     = tx_q[0] & ~cs_n_q;

`ifdef SPI_MASTER_LOOPBACK_EN
    logic unused_miso;
    assign unused_miso = miso;
    assign rx_bit      = mosi;
`else
    assign rx_bit = miso;
`endif

    spi_clk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_clk_gen (
        .clk_i    (sclk),
        .rst_ni   (rst_n),
        .en_i     (!gen_clr),
        .clr_i    (gen_clr),
        .tgl_i    (gen_tgl),
        .tick_o   (tick),
        .spi_clk_o(spi_clk)
    );

    always_comb begin
        state_d    = state_q;
        cs_n_d     = cs_n_q;
        done_d     = 1'b0;
        data_out_d = data_out_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        bit_cnt_d  = bit_cnt_q;
        unique case (state_q)
            IDLE: if (start) begin
                state_d   = SETUP;
                cs_n_d    = 1'b0;
                tx_d      = data_in;
                rx_d      = '0;
                bit_cnt_d = '0;
            end
            SETUP: if (tick) state_d = XFER;
            // spi_clk level before the tick tells which edge this tick produces
            XFER: if (tick) begin
                if (!spi_clk) begin
                    rx_d      = {rx_q[DATA_WIDTH-2:0], rx_bit};
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end else if (bit_cnt_q == CNT_W'(DATA_WIDTH)) begin
                    state_d = HOLD;
                end else begin
                    tx_d = tx_q >> 1;
                end
            end
            HOLD: if (tick) begin
                state_d    = IDLE;
                cs_n_d     = 1'b1;
                done_d     = 1'b1;
                data_out_d = rx_q;
                tx_d       = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cs_n_q     <= 1'b1;
            done_q     <= 1'b0;
            data_out_q <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            bit_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            cs_n_q     <= cs_n_d;
            done_q     <= done_d;
            data_out_q <= data_out_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            bit_cnt_q  <= bit_cnt_d;
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: default instance (8b, div 4) and a 16b/div 2 instance.
module tb_spi_master;

    logic        sclk = 1'b0;
    logic        rst_n;
    logic [1:0]  start, busy, done, spi_clk, cs_n, mosi, miso;
    logic [15:0] din [2];
    logic [15:0] slave_word [2];
    logic [7:0]  dout8;
    logic [15:0] dout16;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    int unsigned rise_cnt [2] = '{0, 0};
    int unsigned done_cnt [2] = '{0, 0};
    logic [15:0] mosi_seen [2] = '{16'h0, 16'h0};
    int unsigned mosi_idle_err = 0;
    logic [1:0]  prev_clk = 2'b00;
    logic [1:0]  prev_cs  = 2'b11;

    always #5 sclk = ~sclk;

    spi_master u_dut8 (
        .sclk    (sclk),
        .rst_n   (rst_n),
        .start   (start[0]),
        .data_in (din[0][7:0]),
        .busy    (busy[0]),
        .done    (done[0]),
        .data_out(dout8),
        .spi_clk (spi_clk[0]),
        .cs_n    (cs_n[0]),
        .mosi    (mosi[0]),
        .miso    (miso[0])
    );

    spi_master #(
        .DATA_WIDTH(16),
        .CLK_DIV   (2)
    ) u_dut16 (
        .sclk    (sclk),
        .rst_n   (rst_n),
        .start   (start[1]),
        .data_in (din[1]),
        .busy    (busy[1]),
        .done    (done[1]),
        .data_out(dout16),
        .spi_clk (spi_clk[1]),
        .cs_n    (cs_n[1]),
        .mosi    (mosi[1]),
        .miso    (miso[1])
    );

    function automatic int unsigned wid(input int i);
        return (i == 0) ? 8 : 16;
    endfunction

    function automatic int unsigned div(input int i);
        return (i == 0) ? 4 : 2;
    endfunction

    function automatic logic [15:0] mask(input int i);
        return (i == 0) ? 16'h00FF : 16'hFFFF;
    endfunction

    function automatic logic [15:0] get_dout(input int i);
        return (i == 0) ? {8'h00, dout8} : dout16;
    endfunction

    // Slave answers MSB-first; loopback receives the LSB-first stream, i.e. the bit-reversed word.
    function automatic logic [15:0] model_rx(input int i, input logic [15:0] tx, input logic [15:0] sw);
        logic [15:0] rev;
        rev = '0;
        for (int k = 0; k < int'(wid(i)); k++) rev[wid(i) - 1 - k] = tx[k];
`ifdef SPI_MASTER_LOOPBACK_EN
        return rev;
`else
        return (rev & 16'h0) | (sw & mask(i));
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    endtask

    // Slave model: presents bit W-1-k before the k-th rising spi_clk edge.
    always_comb begin
        miso = '0;
        for (int i = 0; i < 2; i++) begin
            if (rise_cnt[i] < wid(i)) miso[i] = slave_word[i][wid(i) - 1 - rise_cnt[i]];
        end
    end

    always @(negedge sclk) begin
        for (int i = 0; i < 2; i++) begin
            if (prev_cs[i] && !cs_n[i]) begin
                rise_cnt[i]  <= 0;
                mosi_seen[i] <= '0;
            end else if (!prev_clk[i] && spi_clk[i]) begin
                if (rise_cnt[i] < 16) mosi_seen[i][rise_cnt[i]] <= mosi[i];
                rise_cnt[i] <= rise_cnt[i] + 1;
            end
            if (done[i]) done_cnt[i] <= done_cnt[i] + 1;
            if (cs_n[i] && mosi[i]) mosi_idle_err <= mosi_idle_err + 1;
        end
        prev_clk <= spi_clk;
        prev_cs  <= cs_n;
    end

    task automatic xfer(input int i, input logic [15:0] tx, input logic [15:0] sw, input bit poke);
        int unsigned n, dc0, lat;
        n   = 0;
        lat = 1 + div(i) * (2 * wid(i) + 2);
        @(posedge sclk); #1;
        din[i]        = tx & mask(i);
        slave_word[i] = sw & mask(i);
        start[i]      = 1'b1;
        dc0           = done_cnt[i];
        while (1'b1) begin
            @(posedge sclk); #1;
            n++;
            start[i] = poke && (n == 10);
            if (n == 1) check("busy_after_accept", 32'(busy[i]), 32'd1);
            if (done[i] || n > lat + 20) break;
        end
        check("latency", n, lat);
        check("busy_in_done", 32'(busy[i]), 32'd0);
        check("cs_n_in_done", 32'(cs_n[i]), 32'd1);
        check("rx_word", 32'(get_dout(i)), 32'(model_rx(i, tx, sw)));
        check("rise_edges", rise_cnt[i], wid(i));
        check("mosi_seq", 32'(mosi_seen[i]), 32'(tx & mask(i)));
        if (poke) begin
            repeat (lat) @(posedge sclk);
            #1 check("single_done", done_cnt[i] - dc0, 32'd1);
        end
    endtask

    task automatic back_to_back();
        int unsigned n;
        logic [15:0] sw1, sw2;
        sw1 = 16'($urandom) & 16'h00FF;
        sw2 = 16'($urandom) & 16'h00FF;
        @(posedge sclk); #1;
        din[0] = 16'h00FF; slave_word[0] = sw1; start[0] = 1'b1;
        n = 0;
        while (1'b1) begin
            @(posedge sclk); #1; n++;
            if (done[0] || n > 100) break;
        end
        check("b2b_lat1", n, 32'd73);
        check("b2b_rx1", 32'(get_dout(0)), 32'(model_rx(0, 16'h00FF, sw1)));
        check("b2b_gap_csn_high", 32'(cs_n[0]), 32'd1);
        din[0] = 16'h0000; slave_word[0] = sw2;
        @(posedge sclk); #1;
        n = 1;
        start[0] = 1'b0;
        check("b2b_csn_relow", 32'(cs_n[0]), 32'd0);
        while (1'b1) begin
            if (done[0] || n > 100) break;
            @(posedge sclk); #1; n++;
        end
        check("b2b_done_spacing", n, 32'd73);
        check("b2b_rx2", 32'(get_dout(0)), 32'(model_rx(0, 16'h0000, sw2)));
        check("b2b_mosi2", 32'(mosi_seen[0]), 32'd0);
    endtask

    task automatic reset_abort();
        int unsigned dc0;
        @(posedge sclk); #1;
        din[0] = 16'h00A5; slave_word[0] = 16'h003C; start[0] = 1'b1;
        dc0 = done_cnt[0];
        repeat (30) begin
            @(posedge sclk); #1;
            start[0] = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        check("rst_cs_n", 32'(cs_n[0]), 32'd1);
        check("rst_spi_clk", 32'(spi_clk[0]), 32'd0);
        check("rst_mosi", 32'(mosi[0]), 32'd0);
        check("rst_busy", 32'(busy[0]), 32'd0);
        check("rst_done", 32'(done[0]), 32'd0);
        check("rst_dout", 32'(get_dout(0)), 32'd0);
        repeat (2) @(posedge sclk);
        #1 rst_n = 1'b1;
        repeat (100) @(posedge sclk);
        #1;
        check("abort_no_done", done_cnt[0] - dc0, 32'd0);
        check("abort_dout", 32'(get_dout(0)), 32'd0);
        check("abort_idle_cs_n", 32'(cs_n[0]), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        start = '0;
        din[0] = '0; din[1] = '0;
        slave_word[0] = '0; slave_word[1] = '0;
        repeat (3) @(posedge sclk);
        #1;
        check("reset_cs_n", 32'(cs_n), 32'h3);
        check("reset_spi_clk", 32'(spi_clk), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_done", 32'(done), 32'h0);
        check("reset_dout", 32'(get_dout(1)), 32'h0);
        rst_n = 1'b1;

        reset_abort();
        xfer(0, 16'h00A5, 16'h003C, 1'b0);
        xfer(0, 16'h0081, 16'($urandom), 1'b0);
`ifdef SPI_MASTER_LOOPBACK_EN
        check("loopback_81", 32'(get_dout(0)), 32'h81);
`endif
        xfer(0, 16'h0001, 16'($urandom), 1'b0);
`ifdef SPI_MASTER_LOOPBACK_EN
        check("loopback_01", 32'(get_dout(0)), 32'h80);
`endif
        xfer(0, 16'($urandom), 16'($urandom), 1'b1);
        back_to_back();
        xfer(1, 16'h1234, 16'($urandom), 1'b0);
        for (int r = 0; r < 5; r++) begin
            xfer(0, 16'($urandom), 16'($urandom), 1'b0);
            xfer(1, 16'($urandom), 16'($urandom), 1'b0);
        end
        check("mosi_zero_when_deselected", mosi_idle_err, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter DATA_WIDTH, default 8: bits per transfer, legal range 2..16.
REQ-002 Parameter CLK_DIV, default 4: spi_clk half-period in sclk cycles, legal range 2..255.
REQ-003 sclk  input  1: system clock; all logic on its rising edge; single clock domain.
REQ-004 rst_n  input  1: asynchronous, active-low reset.
REQ-005 start  input  1: one-cycle request to begin a transfer.
REQ-006 data_in  input  DATA_WIDTH: word to transmit; sampled when start is accepted.
REQ-007 busy  output  1: high from the cycle after start is accepted until the cycle done pulses.
REQ-008 done  output  1: one-cycle pulse when a transfer completes.
REQ-009 data_out  output  DATA_WIDTH: word received on miso; updated only with done.
REQ-010 spi_clk  output  1: serial clock, idle low (SPI mode 0).
REQ-011 cs_n  output  1: chip select, active low.
REQ-012 mosi  output  1: serial data to the slave, LSB first.
REQ-013 miso  input  1: serial data from the slave, MSB first.

Function
REQ-014 The FSM SHALL have states IDLE, SETUP, XFER and HOLD; reset enters IDLE.
REQ-015 IDLE: start=1 is accepted; the FSM latches data_in, drives cs_n=0 and mosi=data_in[0], clears the bit counter, and enters SETUP.
REQ-016 start SHALL be ignored in every state except IDLE; the transfer in progress is unaffected.
REQ-017 SETUP SHALL last CLK_DIV cycles with spi_clk=0, then enter XFER.
REQ-018 XFER: spi_clk SHALL toggle every CLK_DIV cycles, starting with a rising edge.
REQ-019 Each spi_clk rising edge: miso sampled and shifted in MSB-first, as rx <= {rx[W-2:0], miso}; the bit counter increments.
REQ-020 Each spi_clk falling edge: mosi advances to the next tx bit, LSB-first.
REQ-021 After the falling edge that follows the DATA_WIDTH-th rising edge, the FSM SHALL enter HOLD with spi_clk=0.
REQ-022 HOLD SHALL last CLK_DIV cycles with cs_n=0; then cs_n=1, done=1 for one cycle, data_out=rx, busy=0, and the FSM enters IDLE.
REQ-023 Latency: done SHALL be high exactly 1+CLK_DIV*(2*DATA_WIDTH+2) cycles after the start-accept edge (73 for defaults).
REQ-024 start asserted in the done cycle SHALL be accepted, giving back-to-back transfers with cs_n high for at least one cycle between them.
REQ-025 The bit counter SHALL be $clog2(DATA_WIDTH+1) bits wide; the half-period counter SHALL be 8 bits wide and wrap to 0 on each toggle.
REQ-026 mosi SHALL be 0 whenever cs_n=1.

Reset
REQ-027 Asserting rst_n low at any time, including mid-transfer, SHALL immediately force: cs_n=1, spi_clk=0, mosi=0, busy=0, done=0, data_out=0, state IDLE, all counters and shift registers 0.
REQ-028 A transfer aborted by reset SHALL NOT produce done and SHALL NOT update data_out.

Configuration
REQ-029 Macro SPI_MASTER_LOOPBACK_EN defined: the receive shifter samples internal mosi instead of the miso pin, and miso is ignored.
REQ-030 Macro SPI_MASTER_LOOPBACK_EN undefined: miso is used as specified; no loopback logic is present.

Structure
REQ-031 Package spi_pkg SHALL hold the FSM state encoding (IDLE=0, SETUP=1, XFER=2, HOLD=3) and the default DATA_WIDTH and CLK_DIV constants.
REQ-032 Sub-module spi_clk_gen SHALL produce the half-period tick and the spi_clk level from CLK_DIV, with enable and clear inputs; the FSM SHALL live in spi_master.

Verification
REQ-033 Defaults, data_in=8'hA5, slave model returns 8'h3C MSB-first -> mosi shows 1,0,1,0,0,1,0,1 on successive rising edges; data_out=8'h3C; done at cycle 73; exactly 8 rising edges.
REQ-034 start pulsed again 10 cycles into a transfer -> ignored; exactly one done; spi_clk edge count stays 8.
REQ-035 start held high through the done cycle with data_in=8'hFF then 8'h00 -> two back-to-back transfers; cs_n high for 1 cycle between them; the second done lands 73 cycles after the first.
REQ-036 rst_n low at cycle 30 of a transfer -> cs_n=1 and spi_clk=0 asynchronously; no done; data_out stays 0.
REQ-037 SPI_MASTER_LOOPBACK_EN defined, data_in=8'h81 -> data_out=8'h81 for defaults: the loopback transmits 1,0,0,0,0,0,0,1 (LSB-first) and receives MSB-first, a bit reversal that leaves the palindromic 8'h81 unchanged; repeat with 8'h01 -> data_out=8'h80.
REQ-038 CLK_DIV=2, DATA_WIDTH=16, data_in=16'h1234 -> done at cycle 1+2*34=69; 16 rising edges; received word matches the slave model.
